// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
//
// Wormhole switch allocator and crossbar controller for the 5-port mesh
// router. Each output port runs a small IDLE/LOCKED state machine. While
// IDLE it round-robin arbitrates among the inputs that want it. While
// LOCKED it stays with its winning input until that packet's tail flit has
// crossed. Downstream buffer credits are tracked per output. Transfers only
// happen while the output holds at least one credit.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   req_valid  [NPORT]        input i has a flit at its FIFO head
//   req_dst    [NPORT*IDXW]   destination of input i at [i*IDXW +: IDXW]
//   req_tail   [NPORT]        head flit of input i is a packet tail
//   credit_in  [NPORT]        output j's downstream freed one slot (pulse)
//   rd_en      [NPORT]        pop FIFO i this cycle
//   sel        [NPORT*NPORT]  one-hot input select of output j at [j*NPORT +: NPORT]
//   out_valid  [NPORT]        output j carries a valid flit this cycle
//   locked     [NPORT]        output j is owned by an input
//   dst_err    1              registered pulse: a valid request had req_dst >= NPORT
// ---------------------------------------------------------------------------
module switch_allocator #(
   parameter int NPORT   = 5,
   parameter int IDXW    = 3,
   parameter int CREDITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORT-1:0]         req_valid,
   input  logic [NPORT*IDXW-1:0]    req_dst,
   input  logic [NPORT-1:0]         req_tail,
   input  logic [NPORT-1:0]         credit_in,
   output logic [NPORT-1:0]         rd_en,
   output logic [NPORT*NPORT-1:0]   sel,
   output logic [NPORT-1:0]         out_valid,
   output logic [NPORT-1:0]         locked,
   output logic                     dst_err
);

   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            r_state     [NPORT];
   state_t            w_stateNext [NPORT];
   logic [IDXW-1:0]   r_owner     [NPORT];
   logic [IDXW-1:0]   w_ownerNext [NPORT];
   logic [IDXW-1:0]   r_ptr       [NPORT];
   logic [IDXW-1:0]   w_ptrNext   [NPORT];
   logic [CW-1:0]     r_credit    [NPORT];
   logic [CW-1:0]     w_creditNext[NPORT];
   logic [NPORT-1:0]  w_ownerBusy;
   logic [NPORT-1:0]  w_xfer;
   logic              w_badDst;
   logic              r_dstErr;

   assign dst_err = r_dstErr;

   // An input that already owns some locked output is mid-packet, so it may
   // not win another output even though its destination field matches.
   // This also keeps two outputs from ever granting the same input.
   always_comb begin
      w_ownerBusy = '0;
      for (int j = 0; j < NPORT; j++) begin
         for (int i = 0; i < NPORT; i++) begin
            if (r_state[j] == LOCKED && r_owner[j] == IDXW'(i)) begin
               w_ownerBusy[i] = 1'b1;
            end
         end
      end
   end

   // Any valid request naming a non-existent output is flagged. It can
   // never match an output index, so it is never granted.
   always_comb begin
      w_badDst = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (req_valid[i] && ({1'b0, req_dst[i*IDXW +: IDXW]} >= (IDXW+1)'(NPORT))) begin
            w_badDst = 1'b1;
         end
      end
   end

   // Per-output next-state and crossbar outputs.
   // LOCKED: hold the select on the owner. Move a flit when the owner has
   // one and a credit is available. Release on the tail and advance the
   // round-robin pointer past the owner.
   // IDLE: scan from the pointer upward with wrap and lock the first
   // eligible input. No credit is needed to allocate.
   always_comb begin
      int   idx;
      logic found;
      idx       = 0;
      found     = 1'b0;
      rd_en     = '0;
      sel       = '0;
      out_valid = '0;
      locked    = '0;
      w_xfer    = '0;
      for (int j = 0; j < NPORT; j++) begin
         w_stateNext[j]  = r_state[j];
         w_ownerNext[j]  = r_owner[j];
         w_ptrNext[j]    = r_ptr[j];
         w_creditNext[j] = r_credit[j];
         found           = 1'b0;
         if (r_state[j] == LOCKED) begin
            locked[j] = 1'b1;
            sel[j*NPORT + int'(r_owner[j])] = 1'b1;
            if (req_valid[r_owner[j]] && r_credit[j] != '0) begin
               w_xfer[j]            = 1'b1;
               out_valid[j]         = 1'b1;
               rd_en[r_owner[j]]    = 1'b1;
               if (req_tail[r_owner[j]]) begin
                  w_stateNext[j] = IDLE;
                  w_ptrNext[j]   = (r_owner[j] == IDXW'(NPORT-1)) ? '0 : r_owner[j] + 1'b1;
               end
            end
         end else begin
            for (int k = 0; k < NPORT; k++) begin
               idx = int'(r_ptr[j]) + k;
               if (idx >= NPORT) begin
                  idx = idx - NPORT;
               end
               if (!found && req_valid[idx] && !w_ownerBusy[idx] &&
                   req_dst[idx*IDXW +: IDXW] == IDXW'(j)) begin
                  found          = 1'b1;
                  w_ownerNext[j] = IDXW'(idx);
                  w_stateNext[j] = LOCKED;
               end
            end
         end
         // A returning credit and a departing flit in the same cycle cancel.
         // Credits beyond the downstream depth are ignored.
         if (w_xfer[j] && !credit_in[j]) begin
            w_creditNext[j] = r_credit[j] - 1'b1;
         end else if (!w_xfer[j] && credit_in[j] && r_credit[j] < CW'(CREDITS)) begin
            w_creditNext[j] = r_credit[j] + 1'b1;
         end
      end
   end

   // State register. Reset drops every lock immediately. Truncated packets
   // are left for the upstream logic to deal with.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NPORT; j++) begin
            r_state[j]  <= IDLE;
            r_owner[j]  <= '0;
            r_ptr[j]    <= '0;
            r_credit[j] <= CW'(CREDITS);
         end
         r_dstErr <= 1'b0;
      end else begin
         for (int j = 0; j < NPORT; j++) begin
            r_state[j]  <= w_stateNext[j];
            r_owner[j]  <= w_ownerNext[j];
            r_ptr[j]    <= w_ptrNext[j];
            r_credit[j] <= w_creditNext[j];
         end
         r_dstErr <= w_badDst;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
//
// Directed bench for the switch allocator. Each input is modelled as a FIFO
// holding srcRem flits, grouped into packets of srcLen flits. The FIFO pops
// whenever the DUT raised rd_en for it. Every flit expected on output j is
// queued in expQ[j] when its packet is loaded. Each flit the DUT actually
// sends is popped from that queue and checked for the right source.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

   localparam int NPORT = 5;
   localparam int IDXW  = 3;

   logic                   clk;
   logic                   rst;
   logic [NPORT-1:0]       req_valid;
   logic [NPORT*IDXW-1:0]  req_dst;
   logic [NPORT-1:0]       req_tail;
   logic [NPORT-1:0]       credit_in;
   logic [NPORT-1:0]       rd_en;
   logic [NPORT*NPORT-1:0] sel;
   logic [NPORT-1:0]       out_valid;
   logic [NPORT-1:0]       locked;
   logic                   dst_err;

   int                     checks;
   int                     failures;
   int                     srcRem [NPORT];
   int                     srcLen [NPORT];
   logic [IDXW-1:0]        srcDst [NPORT];
   logic [NPORT-1:0]       nextCredit;
   logic [NPORT-1:0]       creditAlways;
   logic [NPORT*NPORT-1:0] expSel;
   int                     expQ [NPORT][$];

   switch_allocator #(.NPORT(5), .IDXW(3), .CREDITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_dst   (req_dst),
      .req_tail  (req_tail),
      .credit_in (credit_in),
      .rd_en     (rd_en),
      .sel       (sel),
      .out_valid (out_valid),
      .locked    (locked),
      .dst_err   (dst_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a wedged run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison. It counts itself and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive every input FIFO head from the source model.
   task automatic applyStimulus();
      for (int i = 0; i < NPORT; i++) begin
         req_valid[i]               = (srcRem[i] > 0);
         req_dst[i*IDXW +: IDXW]    = srcDst[i];
         req_tail[i]                = (srcRem[i] > 0) && (((srcRem[i] - 1) % srcLen[i]) == 0);
      end
   endtask

   // Close the current cycle and open the next one. First the outputs of
   // the current cycle are scoreboarded and the pops latched. Then the
   // clock edge passes. Then the FIFO model and credit pulses advance, and
   // the new inputs are allowed to settle before the caller checks them.
   task automatic tick();
      logic [NPORT-1:0] popped;
      int               exp;
      int               obs;
      popped = rd_en;
      for (int j = 0; j < NPORT; j++) begin
         if (out_valid[j]) begin
            if (expQ[j].size() > 0) begin
               exp = expQ[j].pop_front();
               obs = -1;
               for (int k = 0; k < NPORT; k++) begin
                  if (sel[j*NPORT + k]) obs = k;
               end
               checkOutput($sformatf("sb_src_out%0d", j), obs, exp);
               checkOutput($sformatf("sb_rden_out%0d", j), {31'd0, rd_en[exp]}, 1);
            end else begin
               checkOutput($sformatf("sb_unexpected_flit_out%0d", j), {31'd0, out_valid[j]}, 0);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NPORT; i++) begin
         if (popped[i] && srcRem[i] > 0) srcRem[i]--;
      end
      applyStimulus();
      credit_in  = nextCredit | creditAlways;
      nextCredit = '0;
      #2;
   endtask

   task automatic loadPacket(input int src, input int dst, input int len, input int flits);
      srcDst[src] = IDXW'(dst);
      srcLen[src] = len;
      srcRem[src] = flits;
      if (dst < NPORT) begin
         for (int f = 0; f < flits; f++) expQ[dst].push_back(src);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      req_valid    = '0;
      req_dst      = '0;
      req_tail     = '0;
      credit_in    = '0;
      nextCredit   = '0;
      creditAlways = '0;
      for (int i = 0; i < NPORT; i++) begin
         srcRem[i] = 0;
         srcLen[i] = 1;
         srcDst[i] = '0;
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      checkOutput("reset_rd_en", rd_en, 0);
      checkOutput("reset_sel", sel, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_locked", locked, 0);
      checkOutput("reset_dst_err", dst_err, 0);
      rst = 1'b0;

      // Single flow: input 2 sends 3 flits to output 4.
      loadPacket(2, 4, 3, 3);
      tick();
      checkOutput("t1_c0_locked", locked, 0);
      checkOutput("t1_c0_out_valid", out_valid, 0);
      tick();
      checkOutput("t1_c1_locked", locked, 5'b10000);
      checkOutput("t1_c1_out_valid", out_valid, 5'b10000);
      checkOutput("t1_c1_rd_en", rd_en, 5'b00100);
      checkOutput("t1_c1_sel4", sel[4*NPORT +: NPORT], 5'b00100);
      tick();
      checkOutput("t1_c2_out_valid", out_valid, 5'b10000);
      tick();
      checkOutput("t1_c3_out_valid", out_valid, 5'b10000);
      checkOutput("t1_c3_sel4", sel[4*NPORT +: NPORT], 5'b00100);
      tick();
      checkOutput("t1_c4_locked", locked, 0);
      checkOutput("t1_c4_out_valid", out_valid, 0);

      // Output 4 is left with one credit. A 2-flit packet moves one flit,
      // stalls with the select held, and finishes after one credit.
      loadPacket(2, 4, 2, 2);
      tick();
      tick();
      checkOutput("t1b_c1_out_valid", out_valid, 5'b10000);
      tick();
      checkOutput("t1b_c2_out_valid", out_valid, 0);
      checkOutput("t1b_c2_rd_en", rd_en, 0);
      checkOutput("t1b_c2_locked", locked, 5'b10000);
      checkOutput("t1b_c2_sel4", sel[4*NPORT +: NPORT], 5'b00100);
      nextCredit = 5'b10000;
      tick();
      checkOutput("t1b_c3_out_valid", out_valid, 0);
      tick();
      checkOutput("t1b_c4_out_valid", out_valid, 5'b10000);
      creditAlways = 5'b10000;
      tick();
      checkOutput("t1b_c5_locked", locked, 0);
      repeat (3) tick();
      creditAlways = '0;

      // Contention on output 2 from inputs 0, 1, 3, with credits kept topped up.
      creditAlways = 5'b00100;
      srcDst[0] = 3'd2; srcLen[0] = 1; srcRem[0] = 2;
      srcDst[1] = 3'd2; srcLen[1] = 1; srcRem[1] = 2;
      srcDst[3] = 3'd2; srcLen[3] = 1; srcRem[3] = 2;
      for (int r = 0; r < 2; r++) begin
         expQ[2].push_back(0);
         expQ[2].push_back(1);
         expQ[2].push_back(3);
      end
      for (int c = 0; c <= 12; c++) begin
         tick();
         checkOutput($sformatf("t2_c%0d_out_valid", c), out_valid,
                     ((c % 2) == 1 && c <= 11) ? 5'b00100 : 5'b00000);
      end
      creditAlways = '0;

      // Credit stall on output 1: a 6-flit packet from input 0 with 4 credits.
      loadPacket(0, 1, 6, 6);
      tick();
      checkOutput("t3_c0_locked", locked, 0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checkOutput($sformatf("t3_c%0d_out_valid", c), out_valid, 5'b00010);
         checkOutput($sformatf("t3_c%0d_rd_en", c), rd_en, 5'b00001);
      end
      tick();
      checkOutput("t3_c5_out_valid", out_valid, 0);
      checkOutput("t3_c5_rd_en", rd_en, 0);
      checkOutput("t3_c5_sel1", sel[1*NPORT +: NPORT], 5'b00001);
      checkOutput("t3_c5_locked", locked, 5'b00010);
      nextCredit = 5'b00010;
      tick();
      checkOutput("t3_c6_out_valid", out_valid, 0);
      tick();
      checkOutput("t3_c7_out_valid", out_valid, 5'b00010);
      checkOutput("t3_c7_rd_en", rd_en, 5'b00001);
      tick();
      checkOutput("t3_c8_out_valid", out_valid, 0);
      checkOutput("t3_c8_sel1", sel[1*NPORT +: NPORT], 5'b00001);
      creditAlways = 5'b00010;
      tick();
      checkOutput("t3_c9_out_valid", out_valid, 0);
      tick();
      checkOutput("t3_c10_out_valid", out_valid, 5'b00010);
      tick();
      checkOutput("t3_c11_locked", locked, 0);
      tick();
      creditAlways = '0;

      // Credit boundaries on output 3. Two credits while full are ignored.
      // A credit arriving with a transfer cancels it, so exactly 5 flits pass.
      creditAlways = 5'b01000;
      repeat (2) tick();
      creditAlways = '0;
      loadPacket(4, 3, 8, 8);
      tick();
      checkOutput("t4_c0_locked", locked, 0);
      tick();
      checkOutput("t4_c1_out_valid", out_valid, 5'b01000);
      nextCredit = 5'b01000;
      for (int c = 2; c <= 5; c++) begin
         tick();
         checkOutput($sformatf("t4_c%0d_out_valid", c), out_valid, 5'b01000);
      end
      tick();
      checkOutput("t4_c6_out_valid", out_valid, 0);
      checkOutput("t4_c6_locked", locked, 5'b01000);
      tick();
      checkOutput("t4_c7_out_valid", out_valid, 0);
      creditAlways = 5'b01000;
      tick();
      checkOutput("t4_c8_out_valid", out_valid, 0);
      for (int c = 9; c <= 11; c++) begin
         tick();
         checkOutput($sformatf("t4_c%0d_out_valid", c), out_valid, 5'b01000);
      end
      tick();
      checkOutput("t4_c12_locked", locked, 0);
      repeat (2) tick();
      creditAlways = '0;

      // Parallel allocation: input i targets output 4-i.
      expSel = '0;
      for (int i = 0; i < NPORT; i++) begin
         loadPacket(i, 4 - i, 1, 1);
         expSel[(4 - i)*NPORT + i] = 1'b1;
      end
      tick();
      checkOutput("t5_c0_locked", locked, 0);
      tick();
      checkOutput("t5_c1_locked", locked, 5'b11111);
      checkOutput("t5_c1_out_valid", out_valid, 5'b11111);
      checkOutput("t5_c1_rd_en", rd_en, 5'b11111);
      checkOutput("t5_c1_sel", sel, expSel);
      tick();
      checkOutput("t5_c2_locked", locked, 0);

      // Invalid destination on input 1.
      loadPacket(1, 7, 1, 1);
      tick();
      checkOutput("t5b_c0_dst_err", dst_err, 0);
      tick();
      checkOutput("t5b_c1_dst_err", dst_err, 1);
      checkOutput("t5b_c1_locked", locked, 0);
      checkOutput("t5b_c1_rd_en", rd_en, 0);
      srcRem[1] = 0;
      tick();
      checkOutput("t5b_c2_dst_err", dst_err, 1);
      tick();
      checkOutput("t5b_c3_dst_err", dst_err, 0);

      // Reset during flit 2 of a 4-flit packet from input 1 to output 2.
      loadPacket(1, 2, 4, 4);
      tick();
      tick();
      checkOutput("t6_c1_out_valid", out_valid, 5'b00100);
      checkOutput("t6_c1_sel2", sel[2*NPORT +: NPORT], 5'b00010);
      tick();
      checkOutput("t6_c2_out_valid", out_valid, 5'b00100);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_rd_en", rd_en, 0);
      checkOutput("t6_rst_sel", sel, 0);
      checkOutput("t6_rst_out_valid", out_valid, 0);
      checkOutput("t6_rst_locked", locked, 0);
      checkOutput("t6_rst_dst_err", dst_err, 0);
      srcRem[1] = 0;
      expQ[2].delete();
      tick();
      rst = 1'b0;

      // Pointer back at 0: input 0 beats input 3. Credits back at 4, so
      // four flits pass before the stall.
      loadPacket(0, 2, 5, 5);
      loadPacket(3, 2, 1, 1);
      tick();
      checkOutput("t6_d0_locked", locked, 0);
      tick();
      checkOutput("t6_d1_sel2", sel[2*NPORT +: NPORT], 5'b00001);
      checkOutput("t6_d1_out_valid", out_valid, 5'b00100);
      for (int c = 2; c <= 4; c++) begin
         tick();
         checkOutput($sformatf("t6_d%0d_out_valid", c), out_valid, 5'b00100);
      end
      tick();
      checkOutput("t6_d5_out_valid", out_valid, 0);
      checkOutput("t6_d5_locked", locked, 5'b00100);
      creditAlways = 5'b00100;
      tick();
      checkOutput("t6_d6_out_valid", out_valid, 0);
      tick();
      checkOutput("t6_d7_out_valid", out_valid, 5'b00100);
      tick();
      checkOutput("t6_d8_locked", locked, 0);
      tick();
      checkOutput("t6_d9_out_valid", out_valid, 5'b00100);
      checkOutput("t6_d9_sel2", sel[2*NPORT +: NPORT], 5'b01000);
      tick();
      checkOutput("t6_d10_locked", locked, 0);
      creditAlways = '0;

      for (int j = 0; j < NPORT; j++) begin
         checkOutput($sformatf("sb_queue_empty_out%0d", j), expQ[j].size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Wormhole switch allocator and crossbar controller for the 5-port mesh router.
- Sits between the input FIFOs plus route-compute stage and the crossbar.
- Arbitrates input FIFOs competing for each output port with a per-output round-robin policy, and locks each output to its winning input until that packet's tail flit has passed.
- Tracks downstream buffer credits per output, and drives the crossbar one-hot selects and the FIFO read enables.

Parameters:
- NPORT, 5, number of router ports (inputs = outputs).
- IDXW, 3, width of a destination port index.
- CREDITS, 4, downstream FIFO depth; reset value and ceiling of each credit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NPORT  input i has a flit at its FIFO head.
- req_dst  in  NPORT*IDXW  destination output index of input i, at [i*IDXW +: IDXW].
- req_tail  in  NPORT  head flit of input i is a packet tail (single-flit packets have head = tail).
- credit_in  in  NPORT  one-cycle pulse: output j's downstream freed one slot.
- rd_en  out  NPORT  pop FIFO i this cycle (the flit transfers this cycle).
- sel  out  NPORT*NPORT  one-hot input select for output j, at [j*NPORT +: NPORT].
- out_valid  out  NPORT  output j carries a valid flit this cycle.
- locked  out  NPORT  output j is owned by an input.
- dst_err  out  1  registered one-cycle pulse: a valid request carried req_dst >= NPORT.

Behaviour:
- Reset:
  - All outputs IDLE, owner registers 0, sel = 0, rd_en = 0, out_valid = 0, locked = 0, dst_err = 0.
  - Credit counters = CREDITS.
  - Round-robin pointers = 0, so input 0 has top priority.
- Per-output FSM, two states:
  - IDLE.
  - LOCKED, with owner index o_j.
- Eligibility for output j: input i is eligible when req_valid[i] && req_dst[i] == j && input i is not the owner of any LOCKED output.
- Allocation in IDLE:
  - If any input is eligible, the winner is the first eligible input scanning from ptr_j upward with wrap (ptr_j, ptr_j+1, ..., NPORT-1, 0, ...).
  - At the clock edge: o_j <= winner, state <= LOCKED.
  - Allocation does not require credit.
  - Allocation latency is 1 cycle: request in cycle N, first possible transfer in cycle N+1.
- Transfer in LOCKED (combinational from registers and inputs):
  - xfer_j = req_valid[o_j] && credit_j > 0.
  - sel_j = onehot(o_j) for the whole time the output is LOCKED, including stall cycles.
  - out_valid[j] = xfer_j; rd_en[o_j] = xfer_j.
  - In IDLE, sel_j = 0 and out_valid[j] = 0.
- Release: when xfer_j && req_tail[o_j], then at the clock edge state <= IDLE and ptr_j <= o_j + 1 (mod NPORT).
- Re-allocation: a released output re-arbitrates in the following cycle, so there is exactly one bubble cycle between the tail of one packet and the head of the next on the same output.
- Credits:
  - credit_j decrements on xfer_j and increments on credit_in[j].
  - Both in the same cycle: unchanged.
  - credit_in[j] while credit_j == CREDITS: ignored, counter saturates.
  - credit_j == 0 stalls the output with sel held, out_valid = 0, rd_en = 0.
- Multiple outputs are independent. Several may allocate in the same cycle, and they never pick the same input because each input names exactly one destination.
- Invalid destination: a request with req_dst >= NPORT is never granted. dst_err pulses in the cycle after each cycle in which such a request is present.
- An owner whose req_valid drops mid-packet holds the lock. The output stalls and does not time out.
- locked[j] = (state_j == LOCKED).
- Reset asserted mid-packet clears all state immediately. Truncated packets are the upstream's responsibility.

Test Plan:
1. Single flow: input 2 sends a 3-flit packet to output 4 with CREDITS = 4.
   - locked[4] = 1 at cycle 1.
   - rd_en[2], out_valid[4] high in cycles 1-3, with sel[4*5 +: 5] = 5'b00100.
   - Output back to IDLE at cycle 4; credit_4 = 1.
2. Contention: inputs 0, 1, 3 all send single-flit packets to output 2 every cycle from reset.
   - Grants occur in order 0, 1, 3, 0, ...
   - Each transfer is followed by one bubble cycle.
3. Credit stall: output 1 with CREDITS = 4 and no credit_in, 6-flit packet from input 0.
   - 4 flits transfer, then out_valid[1] = 0 and rd_en[0] = 0 while sel holds 5'b00001.
   - One credit_in[1] pulse releases exactly 1 flit.
4. Credit boundaries:
   - Simultaneous credit_in[3] and a transfer leave the counter unchanged.
   - credit_in[3] pulses at counter 4 keep it at 4.
5. Parallel allocation:
   - Inputs 0 to 4 target outputs 4, 3, 2, 1, 0 in the same cycle; all five lock in one cycle and transfer concurrently.
   - Separately, req_dst = 7 on input 1: no grant, dst_err pulses.
6. Reset mid-packet: assert rst during flit 2 of 4.
   - All outputs are 0 immediately; credits = 4; locked = 0.
   - The first request after rst deasserts is allocated with pointer 0.
